// File: rtl/omsp_uspi_slave_pkg.sv
// Shared constants for the SPI responder: register map, CTRL/STAT bits, frame width, FSM codes.
package omsp_uspi_slave_pkg;

    localparam int unsigned FRAME_W = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned DATA_W  = 16;

    // Word offsets from BASE_ADDR
    localparam logic [ADDR_W-1:0] OFS_CTRL  = 14'd0;
    localparam logic [ADDR_W-1:0] OFS_TXBUF = 14'd1;
    localparam logic [ADDR_W-1:0] OFS_RXBUF = 14'd2;

    // CTRL/STAT bit positions
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_IE      = 1;
    localparam int unsigned STAT_RXFULL  = 8;
    localparam int unsigned STAT_TXEMPTY = 9;
    localparam int unsigned STAT_OVR     = 10;
    localparam int unsigned STAT_BUSY    = 11;

    // Frame FSM encoding
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/omsp_uspi_slave_if.sv
// Peripheral bus plus SPI pins of the responder, with slave (DUT) and master (environment) views.
interface omsp_uspi_slave_if;
    import omsp_uspi_slave_pkg::*;

    logic [ADDR_W-1:0] per_addr;
    logic [DATA_W-1:0] per_din;
    logic              per_en;
    logic [1:0]        per_we;
    logic [DATA_W-1:0] per_dout;
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              spi_irq_rx;

    modport slave (
        input  per_addr, per_din, per_en, per_we, spi_sclk, spi_cs_n, spi_mosi,
        output per_dout, spi_miso, spi_miso_oe, spi_irq_rx
    );

    modport master (
        output per_addr, per_din, per_en, per_we, spi_sclk, spi_cs_n, spi_mosi,
        input  per_dout, spi_miso, spi_miso_oe, spi_irq_rx
    );

endinterface

// File: rtl/omsp_uspi_slave_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a history flop giving one-cycle edge pulses.
module omsp_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain and edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level  = r_sync;
    assign o_rise_c = r_sync & ~r_prev;
    assign o_fall_c = ~r_sync & r_prev;

endmodule

// File: rtl/omsp_uspi_slave.sv
// SPI mode-0 responder on the openMSP430 peripheral bus: register file, frame FSM, shift registers.
module omsp_uspi_slave
    import omsp_uspi_slave_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 14'h004C,
    parameter logic [FRAME_W-1:0] FILL_BYTE = 8'hFF
) (
    input  logic mclk,
    input  logic puc_rst,
    omsp_uspi_slave_if.slave bus
);

    logic [0:0]         r_state, w_state_nxt;
    logic               r_en, w_en_nxt;
    logic               r_ie, w_ie_nxt;
    logic               r_ovr, w_ovr_nxt;
    logic               r_rxfull, w_rxfull_nxt;
    logic               r_txempty, w_txempty_nxt;
    logic [FRAME_W-1:0] r_txbuf, w_txbuf_nxt;
    logic [FRAME_W-1:0] r_rxbuf, w_rxbuf_nxt;
    logic [FRAME_W-1:0] r_tx_shift, w_tx_shift_nxt;
    logic [FRAME_W-1:0] r_rx_shift, w_rx_shift_nxt;
    logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic               r_miso_oe;
    logic               r_irq;

    logic               w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic               w_cs_lvl, w_cs_rise, w_cs_fall;
    logic               w_mosi_s, w_mosi_rise, w_mosi_fall;

    logic               w_sel_ctrl, w_sel_tx, w_sel_rx;
    logic               w_wr_ctrl_lo, w_wr_ctrl_hi, w_wr_tx, w_rd_rx;
    logic [FRAME_W-1:0] w_load_byte;
    logic [FRAME_W-1:0] w_rx_next;
    logic [DATA_W-1:0]  w_per_dout;
    logic               w_unused;

    omsp_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(mclk), .rst(puc_rst), .i_pin(bus.spi_sclk),
        .o_level(w_sclk_lvl), .o_rise_c(w_sclk_rise), .o_fall_c(w_sclk_fall)
    );

    omsp_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(mclk), .rst(puc_rst), .i_pin(bus.spi_cs_n),
        .o_level(w_cs_lvl), .o_rise_c(w_cs_rise), .o_fall_c(w_cs_fall)
    );

    omsp_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(mclk), .rst(puc_rst), .i_pin(bus.spi_mosi),
        .o_level(w_mosi_s), .o_rise_c(w_mosi_rise), .o_fall_c(w_mosi_fall)
    );

    // Address decode and access strobes
    assign w_sel_ctrl   = bus.per_en && (bus.per_addr == BASE_ADDR + OFS_CTRL);
    assign w_sel_tx     = bus.per_en && (bus.per_addr == BASE_ADDR + OFS_TXBUF);
    assign w_sel_rx     = bus.per_en && (bus.per_addr == BASE_ADDR + OFS_RXBUF);
    assign w_wr_ctrl_lo = w_sel_ctrl && bus.per_we[0];
    assign w_wr_ctrl_hi = w_sel_ctrl && bus.per_we[1];
    assign w_wr_tx      = w_sel_tx && bus.per_we[0];
    assign w_rd_rx      = w_sel_rx && (bus.per_we == 2'b00);

    // Byte presented to the master at a load: TXBUF if fresh, otherwise the filler
    assign w_load_byte = r_txempty ? FILL_BYTE : r_txbuf;
    assign w_rx_next   = {r_rx_shift[FRAME_W-2:0], w_mosi_s};

    // Next-state and register-update logic for the frame FSM and register file
    always_comb begin
        w_state_nxt    = r_state;
        w_en_nxt       = r_en;
        w_ie_nxt       = r_ie;
        w_ovr_nxt      = r_ovr;
        w_rxfull_nxt   = r_rxfull;
        w_txempty_nxt  = r_txempty;
        w_txbuf_nxt    = r_txbuf;
        w_rxbuf_nxt    = r_rxbuf;
        w_tx_shift_nxt = r_tx_shift;
        w_rx_shift_nxt = r_rx_shift;
        w_bit_cnt_nxt  = r_bit_cnt;

        if (w_wr_ctrl_lo) begin
            w_en_nxt = bus.per_din[CTRL_EN];
            w_ie_nxt = bus.per_din[CTRL_IE];
        end
        if (w_wr_ctrl_hi && bus.per_din[STAT_OVR]) begin
            w_ovr_nxt = 1'b0;
        end
        if (w_rd_rx) begin
            w_rxfull_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall && r_en) begin
                    w_state_nxt    = ST_ACTIVE;
                    w_tx_shift_nxt = w_load_byte;
                    w_txempty_nxt  = 1'b1;
                    w_bit_cnt_nxt  = '0;
                end
            end
            ST_ACTIVE: begin
                if (!r_en || w_cs_rise) begin
                    // Abort: drop any partial byte, keep buffers and flags
                    w_state_nxt    = ST_IDLE;
                    w_tx_shift_nxt = '0;
                    w_rx_shift_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                end else if (w_sclk_rise) begin
                    w_rx_shift_nxt = w_rx_next;
                    w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == CNT_W'(FRAME_W - 1)) begin
                        w_rxbuf_nxt  = w_rx_next;
                        w_rxfull_nxt = 1'b1;
                        if (r_rxfull && !w_rd_rx) begin
                            w_ovr_nxt = 1'b1;
                        end
                    end
                end else if (w_sclk_fall) begin
                    if (r_bit_cnt == '0) begin
                        w_tx_shift_nxt = w_load_byte;
                        w_txempty_nxt  = 1'b1;
                    end else begin
                        w_tx_shift_nxt = {r_tx_shift[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A TXBUF write lands after any same-cycle load, so it arms the next load
        if (w_wr_tx) begin
            w_txbuf_nxt   = bus.per_din[FRAME_W-1:0];
            w_txempty_nxt = 1'b0;
        end
    end

    // State and register file
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state    <= ST_IDLE;
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_ovr      <= 1'b0;
            r_rxfull   <= 1'b0;
            r_txempty  <= 1'b1;
            r_txbuf    <= '0;
            r_rxbuf    <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_miso_oe  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_en       <= w_en_nxt;
            r_ie       <= w_ie_nxt;
            r_ovr      <= w_ovr_nxt;
            r_rxfull   <= w_rxfull_nxt;
            r_txempty  <= w_txempty_nxt;
            r_txbuf    <= w_txbuf_nxt;
            r_rxbuf    <= w_rxbuf_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_miso_oe  <= (w_state_nxt == ST_ACTIVE);
            r_irq      <= w_ie_nxt & w_rxfull_nxt;
        end
    end

    // Read mux; zero when not selected so it can be OR-ed onto the bus
    always_comb begin
        w_per_dout = '0;
        if (w_sel_ctrl) begin
            w_per_dout[CTRL_EN]      = r_en;
            w_per_dout[CTRL_IE]      = r_ie;
            w_per_dout[STAT_RXFULL]  = r_rxfull;
            w_per_dout[STAT_TXEMPTY] = r_txempty;
            w_per_dout[STAT_OVR]     = r_ovr;
            w_per_dout[STAT_BUSY]    = (r_state == ST_ACTIVE);
        end else if (w_sel_tx) begin
            w_per_dout = {8'h00, r_txbuf};
        end else if (w_sel_rx) begin
            w_per_dout = {8'h00, r_rxbuf};
        end
    end

    // tx_shift is cleared whenever the FSM leaves ACTIVE, so MISO is 0 while idle
    assign bus.per_dout    = w_per_dout;
    assign bus.spi_miso    = r_tx_shift[FRAME_W-1];
    assign bus.spi_miso_oe = r_miso_oe;
    assign bus.spi_irq_rx  = r_irq;

    assign w_unused = ^{bus.per_din[15:11], bus.per_din[9:8], w_sclk_lvl, w_cs_lvl,
                        w_mosi_rise, w_mosi_fall};

endmodule

// File: tb/tb_omsp_uspi_slave.sv
// Directed bench for omsp_uspi_slave: acts as bus master and SPI master at sclk = mclk/8.
module tb_omsp_uspi_slave;

    localparam logic [13:0] BASE   = 14'h004C;
    localparam logic [13:0] A_CTRL = BASE;
    localparam logic [13:0] A_TX   = BASE + 14'd1;
    localparam logic [13:0] A_RX   = BASE + 14'd2;

    logic mclk = 1'b0;
    logic puc_rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [15:0] coinc_rd;

    omsp_uspi_slave_if u_if ();

    omsp_uspi_slave #(.BASE_ADDR(14'h004C), .FILL_BYTE(8'hFF)) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .bus     (u_if.slave)
    );

    always #5 mclk = ~mclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Bus access helpers; all assume they are called just after a falling mclk edge
    task automatic bus_write(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        u_if.per_addr = a;
        u_if.per_din  = d;
        u_if.per_we   = we;
        u_if.per_en   = 1'b1;
        @(negedge mclk);
        u_if.per_en   = 1'b0;
        u_if.per_we   = 2'b00;
    endtask

    task automatic bus_read(input logic [13:0] a, output logic [15:0] d);
        u_if.per_addr = a;
        u_if.per_we   = 2'b00;
        u_if.per_en   = 1'b1;
        #1;
        d = u_if.per_dout;
        @(negedge mclk);
        u_if.per_en   = 1'b0;
    endtask

    task automatic spi_start();
        u_if.spi_cs_n = 1'b0;
        repeat (6) @(negedge mclk);
    endtask

    task automatic spi_stop();
        repeat (4) @(negedge mclk);
        u_if.spi_cs_n = 1'b1;
        repeat (6) @(negedge mclk);
    endtask

    // Mode-0 master: shift nbits of mo MSB first; optionally read RXBUF in the completion cycle
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit rd_last,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            u_if.spi_mosi = mo[i];
            repeat (4) @(negedge mclk);
            mi[i] = u_if.spi_miso;
            u_if.spi_sclk = 1'b1;
            if (rd_last && i == 0) begin
                repeat (2) @(negedge mclk);
                u_if.per_addr = A_RX;
                u_if.per_we   = 2'b00;
                u_if.per_en   = 1'b1;
                #1;
                coinc_rd = u_if.per_dout;
                @(negedge mclk);
                u_if.per_en   = 1'b0;
                @(negedge mclk);
            end else begin
                repeat (4) @(negedge mclk);
            end
            u_if.spi_sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        #1;
        n_checks++; if (u_if.spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe got=%b exp=0", u_if.spi_miso_oe); end
        n_checks++; if (u_if.spi_miso !== 1'b0) begin n_fail++; $display("FAIL rst_miso got=%b exp=0", u_if.spi_miso); end
        n_checks++; if (u_if.spi_irq_rx !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", u_if.spi_irq_rx); end
        repeat (2) @(negedge mclk);
        puc_rst = 1'b0;
        @(negedge mclk);
        n_checks++; if (u_if.per_dout !== 16'h0000) begin n_fail++; $display("FAIL rst_dout got=%h exp=0000", u_if.per_dout); end
        bus_read(A_CTRL, d);
        n_checks++; if (d !== 16'h0200) begin n_fail++; $display("FAIL rst_ctrl got=%h exp=0200", d); end
    endtask

    task automatic test_basic();
        logic [15:0] d;
        logic [7:0]  mi;
        bus_write(A_CTRL, 16'h0001, 2'b01);
        bus_write(A_TX, 16'h00A5, 2'b01);
        bus_read(A_CTRL, d);
        n_checks++; if (d !== 16'h0001) begin n_fail++; $display("FAIL basic_ctrl_pre got=%h exp=0001", d); end
        spi_start();
        n_checks++; if (u_if.spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL basic_oe got=%b exp=1", u_if.spi_miso_oe); end
        spi_xfer(8'h3C, 8, 1'b0, mi);
        spi_stop();
        n_checks++; if (mi !== 8'hA5) begin n_fail++; $display("FAIL basic_miso got=%h exp=a5", mi); end
        bus_read(A_CTRL, d);
        n_checks++; if (d !== 16'h0301) begin n_fail++; $display("FAIL basic_ctrl_post got=%h exp=0301", d); end
        bus_read(A_RX, d);
        n_checks++; if (d !== 16'h003C) begin n_fail++; $display("FAIL basic_rxbuf got=%h exp=003c", d); end
        bus_read(A_CTRL, d);
        n_checks++; if (d !== 16'h0201) begin n_fail++; $display("FAIL basic_rxfull_clr got=%h exp=0201", d); end
    endtask

    task automatic test_overrun();
        logic [15:0] d;
        logic [7:0]  mi;
        bus_write(A_CTRL, 16'h0003, 2'b01);
        spi_start();
        spi_xfer(8'h01, 8, 1'b0, mi);
        n_checks++; if (mi !== 8'hFF) begin n_fail++; $display("FAIL ovr_miso1 got=%h exp=ff", mi); end
        n_checks++; if (u_if.spi_irq_rx !== 1'b1) begin n_fail++; $display("FAIL ovr_irq1 got=%b exp=1", u_if.spi_irq_rx); end
        spi_xfer(8'h02, 8, 1'b0, mi);
        spi_stop();
        n_checks++; if (mi !== 8'hFF) begin n_fail++; $display("FAIL ovr_miso2 got=%h exp=ff", mi); end
        bus_read(A_CTRL, d);
        n_checks++; if (d !== 16'h0703) begin n_fail++; $display("FAIL ovr_ctrl got=%h exp=0703", d); end
        bus_write(A_CTRL, 16'h0400, 2'b10);
        bus_read(A_CTRL, d);
        n_checks++; if (d !== 16'h0303) begin n_fail++; $display("FAIL ovr_w1c got=%h exp=0303", d); end
        bus_read(A_RX, d);
        n_checks++; if (d !== 16'h0002) begin n_fail++; $display("FAIL ovr_rxbuf got=%h exp=0002", d); end
        n_checks++; if (u_if.spi_irq_rx !== 1'b0) begin n_fail++; $display("FAIL ovr_irq_drop got=%b exp=0", u_if.spi_irq_rx); end
    endtask

    task automatic test_abort();
        logic [15:0] d;
        logic [7:0]  mi;
        spi_start();
        spi_xfer(8'hF0, 5, 1'b0, mi);
        spi_stop();
        n_checks++; if (dut.r_bit_cnt !== 3'd0) begin n_fail++; $display("FAIL abort_bitcnt got=%0d exp=0", dut.r_bit_cnt); end
        n_checks++; if (u_if.spi_irq_rx !== 1'b0) begin n_fail++; $display("FAIL abort_irq got=%b exp=0", u_if.spi_irq_rx); end
        bus_read(A_CTRL, d);
        n_checks++; if (d !== 16'h0203) begin n_fail++; $display("FAIL abort_ctrl got=%h exp=0203", d); end
        spi_start();
        spi_xfer(8'h81, 8, 1'b0, mi);
        spi_stop();
        bus_read(A_CTRL, d);
        n_checks++; if (d !== 16'h0303) begin n_fail++; $display("FAIL abort_next_ctrl got=%h exp=0303", d); end
        bus_read(A_RX, d);
        n_checks++; if (d !== 16'h0081) begin n_fail++; $display("FAIL abort_next_rx got=%h exp=0081", d); end
    endtask

    task automatic test_coincident_read();
        logic [15:0] d;
        logic [7:0]  mi;
        spi_start();
        spi_xfer(8'hAA, 8, 1'b0, mi);
        spi_xfer(8'h55, 8, 1'b1, mi);
        spi_stop();
        n_checks++; if (coinc_rd !== 16'h00AA) begin n_fail++; $display("FAIL coinc_old got=%h exp=00aa", coinc_rd); end
        bus_read(A_CTRL, d);
        n_checks++; if (d !== 16'h0303) begin n_fail++; $display("FAIL coinc_ctrl got=%h exp=0303", d); end
        bus_read(A_RX, d);
        n_checks++; if (d !== 16'h0055) begin n_fail++; $display("FAIL coinc_rxbuf got=%h exp=0055", d); end
    endtask

    task automatic test_disable();
        logic [15:0] d;
        logic [7:0]  mi;
        spi_start();
        spi_xfer(8'h00, 3, 1'b0, mi);
        n_checks++; if (u_if.spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL dis_oe_pre got=%b exp=1", u_if.spi_miso_oe); end
        bus_write(A_CTRL, 16'h0002, 2'b01);
        @(negedge mclk);
        n_checks++; if (u_if.spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL dis_oe got=%b exp=0", u_if.spi_miso_oe); end
        n_checks++; if (u_if.spi_miso !== 1'b0) begin n_fail++; $display("FAIL dis_miso got=%b exp=0", u_if.spi_miso); end
        n_checks++; if (dut.r_bit_cnt !== 3'd0) begin n_fail++; $display("FAIL dis_bitcnt got=%0d exp=0", dut.r_bit_cnt); end
        bus_read(A_CTRL, d);
        n_checks++; if (d !== 16'h0202) begin n_fail++; $display("FAIL dis_ctrl got=%h exp=0202", d); end
        u_if.spi_cs_n = 1'b1;
        repeat (6) @(negedge mclk);
        bus_write(A_CTRL, 16'h0003, 2'b01);
        bus_write(A_TX, 16'h005A, 2'b01);
        spi_start();
        spi_xfer(8'hC3, 8, 1'b0, mi);
        spi_stop();
        n_checks++; if (mi !== 8'h5A) begin n_fail++; $display("FAIL dis_miso_new got=%h exp=5a", mi); end
        bus_read(A_RX, d);
        n_checks++; if (d !== 16'h00C3) begin n_fail++; $display("FAIL dis_rxbuf got=%h exp=00c3", d); end
        bus_read(14'h004F, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL oor_hi got=%h exp=0000", d); end
        bus_read(14'h004B, d);
        n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL oor_lo got=%h exp=0000", d); end
        u_if.per_addr = A_CTRL;
        #1;
        n_checks++; if (u_if.per_dout !== 16'h0000) begin n_fail++; $display("FAIL unsel_dout got=%h exp=0000", u_if.per_dout); end
    endtask

    initial begin
        u_if.per_addr = '0;
        u_if.per_din  = '0;
        u_if.per_en   = 1'b0;
        u_if.per_we   = 2'b00;
        u_if.spi_sclk = 1'b0;
        u_if.spi_cs_n = 1'b1;
        u_if.spi_mosi = 1'b0;
        coinc_rd      = '0;
        @(negedge mclk);
        test_reset();
        test_basic();
        test_overrun();
        test_abort();
        test_coincident_read();
        test_disable();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
